csr_regfile: RTL and testbench

Machine-mode control/status register file for the RV32 core. It holds the architectural CSR state and returns the current value of the addressed CSR combinationally to the CSR read-modify-write unit, which computes the new value and the read/write enables. It commits qualified writes on the next clock edge, captures trap state, restores on `mret`, and runs the cycle/instret counters. It sits beside the integer register file in the execute/writeback boundary.

---
 rtl/csr_pkg.sv | 36 +++
 rtl/csr_counter64.sv | 35 +++
 rtl/csr_regfile.sv | 158 +++++++++++++++
 tb/tb_csr_regfile.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// CSR address map, mstatus field positions and reset constants shared by the
// machine-mode CSR file and its testbench.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // MPP is hardwired to machine mode; MIE/MPIE clear.
    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

    // Architectural mstatus view built from the two stored enable bits.
    function automatic logic [31:0] mstatus_value(input logic mie, input logic mpie);
        logic [31:0] v;
        v               = MSTATUS_RESET;
        v[MSTATUS_MIE]  = mie;
        v[MSTATUS_MPIE] = mpie;
        return v;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with increment enable and independent 32-bit half
// write ports. A write to either half takes precedence over the increment.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    // Half writes replace only their half; otherwise count up with carry.
    always_comb begin
        count_d = count_q;
        if (wr_lo || wr_hi) begin
            if (wr_lo) count_d[31:0]  = wdata;
            if (wr_hi) count_d[63:32] = wdata;
        end else if (inc_en) begin
            count_d = count_q + 64'd1;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: combinational read/illegal decode, write commit,
// trap capture and mret restore. The 64-bit cycle/instret counters exist
// only when CSR_COUNTERS_EN is defined; otherwise their addresses decode as
// unimplemented.
module csr_regfile
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID      = 32'h0000_0000,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE   = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_addr,
    input  logic        csr_read,
    input  logic        csr_write,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        instr_retire,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret,
    output logic [31:0] trap_vector,
    output logic [31:0] epc,
    output logic        irq_enable
);

    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [29:0] mtvec_q, mtvec_d;
    logic [29:0] mepc_q, mepc_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mcause_q, mcause_d;

    logic        addr_impl;
    logic [31:0] rdata;
    logic        wr_ok;
    logic [1:0]  unused_trap_pc_lo;

    assign unused_trap_pc_lo = trap_pc[1:0];

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;
`else
    logic unused_instr_retire;
    assign unused_instr_retire = instr_retire;
`endif

    // Address decode: value of the addressed CSR and whether it exists.
    always_comb begin
        addr_impl = 1'b1;
        rdata     = '0;
        case (csr_addr)
            CSR_MSTATUS:  rdata = mstatus_value(mie_q, mpie_q);
            CSR_MISA:     rdata = MISA_VALUE;
            CSR_MTVEC:    rdata = {mtvec_q, 2'b00};
            CSR_MSCRATCH: rdata = mscratch_q;
            CSR_MEPC:     rdata = {mepc_q, 2'b00};
            CSR_MCAUSE:   rdata = mcause_q;
            CSR_MHARTID:  rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE,    CSR_CYCLE:    rdata = mcycle[31:0];
            CSR_MCYCLEH,   CSR_CYCLEH:   rdata = mcycle[63:32];
            CSR_MINSTRET,  CSR_INSTRET:  rdata = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: rdata = minstret[63:32];
`endif
            default:      addr_impl = 1'b0;
        endcase
    end

    // Address space 0xC00-0xFFF is read-only, so any write there is illegal.
    assign csr_illegal = (csr_read | csr_write) &
                         (~addr_impl | (csr_write & (csr_addr[11:10] == 2'b11)));
    assign wr_ok       = csr_write & ~csr_illegal;
    assign csr_rdata   = rdata;

    // Next state: CSR write first, then mret, then trap, so later overrides win.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mscratch_d = mscratch_q;
        mcause_d   = mcause_q;
        if (wr_ok) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_d  = csr_wdata[MSTATUS_MIE];
                    mpie_d = csr_wdata[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_d    = csr_wdata[31:2];
                CSR_MSCRATCH: mscratch_d = csr_wdata;
                CSR_MEPC:     mepc_d     = csr_wdata[31:2];
                CSR_MCAUSE:   mcause_d   = csr_wdata;
                default: ;
            endcase
        end
        if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
        if (trap_valid) begin
            mepc_d   = trap_pc[31:2];
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end
    end

    // Architectural CSR state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= RESET_VECTOR[31:2];
            mepc_q     <= '0;
            mscratch_q <= '0;
            mcause_q   <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mscratch_q <= mscratch_d;
            mcause_q   <= mcause_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    csr_counter64 u_mcycle (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (1'b1),
        .wr_lo  (wr_ok & (csr_addr == CSR_MCYCLE)),
        .wr_hi  (wr_ok & (csr_addr == CSR_MCYCLEH)),
        .wdata  (csr_wdata),
        .count  (mcycle)
    );

    csr_counter64 u_minstret (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (instr_retire),
        .wr_lo  (wr_ok & (csr_addr == CSR_MINSTRET)),
        .wr_hi  (wr_ok & (csr_addr == CSR_MINSTRETH)),
        .wdata  (csr_wdata),
        .count  (minstret)
    );
`endif

    assign trap_vector = {mtvec_q, 2'b00};
    assign epc         = {mepc_q, 2'b00};
    assign irq_enable  = mie_q;

endmodule

// File: tb/tb_csr_regfile.sv
module tb_csr_regfile;

    localparam logic [31:0] HART = 32'd7;
    localparam logic [31:0] RV   = 32'h0000_1000;
    localparam logic [31:0] MISA = 32'h4000_0100;
`ifdef CSR_COUNTERS_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] csr_addr = '0;
    logic        csr_read = 1'b0;
    logic        csr_write = 1'b0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instr_retire = 1'b0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_cause = '0;
    logic [31:0] trap_pc = '0;
    logic        mret = 1'b0;
    logic [31:0] trap_vector;
    logic [31:0] epc;
    logic        irq_enable;

    always #5 clk = ~clk;

    csr_regfile #(
        .HART_ID      (HART),
        .RESET_VECTOR (RV),
        .MISA_VALUE   (MISA)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .csr_addr     (csr_addr),
        .csr_read     (csr_read),
        .csr_write    (csr_write),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .instr_retire (instr_retire),
        .trap_valid   (trap_valid),
        .trap_cause   (trap_cause),
        .trap_pc      (trap_pc),
        .mret         (mret),
        .trap_vector  (trap_vector),
        .epc          (epc),
        .irq_enable   (irq_enable)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference model: architectural CSR words held as full 32/64-bit values.
    logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cycle, m_instret;

    task automatic m_reset();
        m_mstatus  = 32'h0000_1800;
        m_mtvec    = RV & ~32'h3;
        m_mscratch = 0;
        m_mepc     = 0;
        m_mcause   = 0;
        m_cycle    = 0;
        m_instret  = 0;
    endtask

    function automatic bit m_impl(input logic [11:0] a);
        case (a)
            12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF14: return 1'b1;
            12'hB00, 12'hB80, 12'hB02, 12'hB82,
            12'hC00, 12'hC80, 12'hC02, 12'hC82: return CNT;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic m_illegal(input logic [11:0] a, input logic rd, input logic wr);
        return (rd || wr) && (!m_impl(a) || (wr && a >= 12'hC00));
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        if (!m_impl(a)) return 32'h0;
        case (a)
            12'h300: return m_mstatus;
            12'h301: return MISA;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hF14: return HART;
            12'hB00, 12'hC00: return m_cycle[31:0];
            12'hB80, 12'hC80: return m_cycle[63:32];
            12'hB02, 12'hC02: return m_instret[31:0];
            12'hB82, 12'hC82: return m_instret[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_update();
        logic [31:0] old;
        logic [63:0] ncyc, nins;
        bit wr_ok;
        old   = m_mstatus;
        wr_ok = csr_write && !m_illegal(csr_addr, csr_read, csr_write);
        ncyc  = m_cycle + 64'd1;
        nins  = m_instret + (instr_retire ? 64'd1 : 64'd0);
        if (wr_ok) begin
            case (csr_addr)
                12'h300: m_mstatus  = (csr_wdata & 32'h88) | 32'h1800;
                12'h305: m_mtvec    = csr_wdata & ~32'h3;
                12'h340: m_mscratch = csr_wdata;
                12'h341: m_mepc     = csr_wdata & ~32'h3;
                12'h342: m_mcause   = csr_wdata;
                12'hB00: ncyc = {m_cycle[63:32], csr_wdata};
                12'hB80: ncyc = {csr_wdata, m_cycle[31:0]};
                12'hB02: nins = {m_instret[63:32], csr_wdata};
                12'hB82: nins = {csr_wdata, m_instret[31:0]};
                default: ;
            endcase
        end
        if (mret)
            m_mstatus = 32'h1880 | (old[7] ? 32'h8 : 32'h0);
        if (trap_valid) begin
            m_mstatus = 32'h1800 | (old[3] ? 32'h80 : 32'h0);
            m_mepc    = trap_pc & ~32'h3;
            m_mcause  = trap_cause;
        end
        m_cycle   = ncyc;
        m_instret = nins;
    endtask

    task automatic drive(input logic [11:0] a, input logic rd, input logic wr, input logic [31:0] wd);
        csr_addr     = a;
        csr_read     = rd;
        csr_write    = wr;
        csr_wdata    = wd;
        trap_valid   = 1'b0;
        trap_cause   = '0;
        trap_pc      = '0;
        mret         = 1'b0;
        instr_retire = 1'b0;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic check_model();
        check("rdata",       csr_rdata,   m_read(csr_addr));
        check("illegal",     csr_illegal, m_illegal(csr_addr, csr_read, csr_write));
        check("epc",         epc,         m_mepc);
        check("trap_vector", trap_vector, m_mtvec);
        check("irq_enable",  irq_enable,  m_mstatus[3]);
    endtask

    task automatic advance();
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        settle();
        check_model();
        advance();
    endtask

    typedef struct {
        logic [11:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic        exp_ill;
        logic [11:0] chk_addr;
        logic [31:0] exp_rd;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    logic [11:0] addrs [20];

    initial begin
        tbl[0]  = '{12'h300, 1'b1, 1'b0, 32'h0,         1'b0, 12'h300, 32'h0000_1800};
        tbl[1]  = '{12'h305, 1'b1, 1'b0, 32'h0,         1'b0, 12'h305, RV};
        tbl[2]  = '{12'hF14, 1'b1, 1'b0, 32'h0,         1'b0, 12'hF14, HART};
        tbl[3]  = '{12'h301, 1'b1, 1'b0, 32'h0,         1'b0, 12'h301, MISA};
        tbl[4]  = '{12'h340, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 12'h340, 32'hDEAD_BEEF};
        tbl[5]  = '{12'h305, 1'b0, 1'b1, 32'h8000_0003, 1'b0, 12'h305, 32'h8000_0000};
        tbl[6]  = '{12'h341, 1'b0, 1'b1, 32'h1234_5677, 1'b0, 12'h341, 32'h1234_5674};
        tbl[7]  = '{12'h342, 1'b0, 1'b1, 32'h8000_000B, 1'b0, 12'h342, 32'h8000_000B};
        tbl[8]  = '{12'hF14, 1'b0, 1'b1, 32'h5,         1'b1, 12'hF14, HART};
        tbl[9]  = '{12'h7C0, 1'b1, 1'b0, 32'h0,         1'b1, 12'h7C0, 32'h0};
        tbl[10] = '{12'h7C0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 12'h340, 32'hDEAD_BEEF};
        tbl[11] = '{12'h301, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 12'h301, MISA};
        tbl[12] = '{12'h300, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 12'h300, 32'h0000_1888};
        tbl[13] = '{12'h300, 1'b0, 1'b1, 32'h0,         1'b0, 12'h300, 32'h0000_1800};
        tbl[14] = '{12'hB00, 1'b1, 1'b0, 32'h0,         !CNT, 12'hB80, 32'h0};
        tbl[15] = '{12'hC00, 1'b0, 1'b1, 32'h1,         1'b1, 12'h340, 32'hDEAD_BEEF};
        tbl[16] = '{12'h342, 1'b1, 1'b1, 32'h0,         1'b0, 12'h342, 32'h0};

        addrs = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF14,
                  12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                  12'hC82, 12'h7C0, 12'h000, 12'h344, 12'hF11, 12'h300};

        drive(12'h000, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed table: one access cycle, then a readback cycle.
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].wdata);
            settle();
            check("tbl_illegal", csr_illegal, tbl[i].exp_ill);
            check_model();
            advance();
            drive(tbl[i].chk_addr, 1'b1, 1'b0, 32'h0);
            settle();
            check("tbl_rdata", csr_rdata, tbl[i].exp_rd);
            check_model();
            advance();
        end

        // Set MIE, trap, then mret.
        drive(12'h300, 1'b0, 1'b1, 32'h8); tick();
        drive(12'h000, 1'b0, 1'b0, 32'h0);
        settle(); check("mie_set", irq_enable, 1'b1); check_model(); advance();
        drive(12'h000, 1'b0, 1'b0, 32'h0);
        trap_valid = 1'b1; trap_pc = 32'h104; trap_cause = 32'hB;
        tick();
        drive(12'h342, 1'b1, 1'b0, 32'h0);
        settle();
        check("trap_epc", epc, 32'h104);
        check("trap_mcause", csr_rdata, 32'hB);
        check("trap_mie", irq_enable, 1'b0);
        check_model(); advance();
        drive(12'h300, 1'b1, 1'b0, 32'h0);
        settle(); check("trap_mstatus", csr_rdata, 32'h1880); check_model(); advance();
        drive(12'h000, 1'b0, 1'b0, 32'h0); mret = 1'b1; tick();
        drive(12'h300, 1'b1, 1'b0, 32'h0);
        settle();
        check("mret_mie", irq_enable, 1'b1);
        check("mret_mstatus", csr_rdata, 32'h1888);
        check_model(); advance();

        // Trap beats a same-cycle write to mepc.
        drive(12'h341, 1'b0, 1'b1, 32'h5555_5555);
        trap_valid = 1'b1; trap_pc = 32'h207; trap_cause = 32'h2;
        tick();
        drive(12'h341, 1'b1, 1'b0, 32'h0);
        settle();
        check("trap_vs_wr_epc", epc, 32'h204);
        check("trap_vs_wr_rd", csr_rdata, 32'h204);
        check_model(); advance();

        // Write to an unrelated register still commits under a trap.
        drive(12'h340, 1'b0, 1'b1, 32'hCAFE_0000);
        trap_valid = 1'b1; trap_pc = 32'h300; trap_cause = 32'h3;
        tick();
        drive(12'h340, 1'b1, 1'b0, 32'h0);
        settle(); check("trap_unrel_wr", csr_rdata, 32'hCAFE_0000); check_model(); advance();

        // mret beats a same-cycle write to mstatus.
        drive(12'h300, 1'b0, 1'b1, 32'h8); mret = 1'b1; tick();
        drive(12'h300, 1'b1, 1'b0, 32'h0);
        settle();
        check("mret_vs_wr", csr_rdata, 32'h1880);
        check("mret_vs_wr_irq", irq_enable, 1'b0);
        check_model(); advance();

`ifdef CSR_COUNTERS_EN
        // Low-word preload carries into the high word on the second edge.
        drive(12'hB00, 1'b0, 1'b1, 32'hFFFF_FFFF); tick();
        drive(12'hB00, 1'b1, 1'b0, 32'h0);
        settle(); check("mcycle_preload", csr_rdata, 32'hFFFF_FFFF); check_model(); advance();
        drive(12'hB80, 1'b1, 1'b0, 32'h0);
        settle(); check("mcycle_carry", csr_rdata, 32'h1); check_model(); advance();
        // Written instret value wins over a same-cycle retire.
        drive(12'hB02, 1'b0, 1'b1, 32'h100); instr_retire = 1'b1; tick();
        drive(12'hB02, 1'b1, 1'b0, 32'h0);
        settle(); check("minstret_wr", csr_rdata, 32'h100); check_model(); advance();
        drive(12'hC02, 1'b1, 1'b0, 32'h0);
        settle(); check("instret_shadow", csr_rdata, 32'h100); check_model(); advance();
        drive(12'hB02, 1'b0, 1'b1, 32'hFFFF_FFFF); tick();
        drive(12'h000, 1'b0, 1'b0, 32'h0); instr_retire = 1'b1; tick();
        drive(12'hB82, 1'b1, 1'b0, 32'h0);
        settle(); check("minstret_carry", csr_rdata, 32'h1); check_model(); advance();
        // 64-bit wrap to zero.
        drive(12'hB80, 1'b0, 1'b1, 32'hFFFF_FFFF); tick();
        drive(12'hB00, 1'b0, 1'b1, 32'hFFFF_FFFF); tick();
        drive(12'hB80, 1'b1, 1'b0, 32'h0);
        settle(); check("mcycle_max_hi", csr_rdata, 32'hFFFF_FFFF); check_model(); advance();
        drive(12'hB80, 1'b1, 1'b0, 32'h0);
        settle(); check("mcycle_wrap_hi", csr_rdata, 32'h0); check_model(); advance();
`endif

        // Asynchronous reset in mid-operation.
        drive(12'h340, 1'b1, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        check("rst_async_rdata", csr_rdata, 32'h0);
        check("rst_async_epc", epc, 32'h0);
        check("rst_async_tvec", trap_vector, RV);
        check("rst_async_irq", irq_enable, 1'b0);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(12'hB00, 1'b1, 1'b0, 32'h0); tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [11:0] a;
            a = addrs[$urandom_range(0, 19)];
            if ($urandom_range(0, 15) == 0) a = 12'($urandom);
            drive(a, 1'($urandom), ($urandom_range(0, 2) == 0), $urandom);
            trap_valid   = ($urandom_range(0, 9) == 0);
            trap_pc      = $urandom;
            trap_cause   = $urandom;
            mret         = ($urandom_range(0, 7) == 0);
            instr_retire = 1'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
